// File: rtl/panel_controller_pkg.sv
// Shared constants for the front-panel controller:
// tick defaults, value ranges, repeat FSM encoding, button indices.
package panel_controller_pkg;

  localparam int DEF_DEBOUNCE_TICKS = 2000;
  localparam int DEF_HOLD_TICKS     = 50000;
  localparam int DEF_REPEAT_TICKS   = 10000;

  localparam logic [7:0] DEF_FC_MIN   = 8'd1;
  localparam logic [7:0] DEF_FC_MAX   = 8'd128;
  localparam logic [1:0] DEF_MODE_MAX = 2'd3;
  localparam logic [1:0] RST_MODE     = 2'd0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_LOCK   = 2'd2;
  localparam logic [1:0] ST_REPEAT = 2'd3;

  localparam logic MODE_UP = 1'b1;
  localparam logic MODE_DN = 1'b0;
  localparam logic FC_UP   = 1'b0;
  localparam logic FC_DN   = 1'b1;

endpackage

// File: rtl/panel_controller_if.sv
// Front-panel bundle: raw buttons in, mode/frequency
// state and change pulses out.
interface panel_controller_if;
  logic [1:0] h_pb;
  logic [1:0] v_pb;
  logic [1:0] mode;
  logic [7:0] freq_ctrl;
  logic       mode_evt;
  logic       fc_evt;

  modport master (
    output h_pb, v_pb,
    input  mode, freq_ctrl, mode_evt, fc_evt
  );

  modport slave (
    input  h_pb, v_pb,
    output mode, freq_ctrl, mode_evt, fc_evt
  );
endinterface

// File: rtl/panel_controller_pb_debounce.sv
// One push button: 2-flop synchroniser, stability filter,
// debounced level and a single-cycle press pulse.
module pb_debounce
  import panel_controller_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clk_100kHz,
  input  logic rst_,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic          s1;
  logic          s2;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (s2 != level)
             && (cnt == CW'(DEBOUNCE_TICKS - 1));

  // Synchroniser resets high and presses need a seen
  // release first, so a button held through reset is inert.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= flip & s2 & armed;
      armed <= armed | (~s2 & ~level);
      if (s2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        cnt   <= '0;
        level <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/panel_controller.sv
// Front-panel controller: debounced mode select and
// frequency word with hold-to-repeat on the freq buttons.
module panel_controller
  import panel_controller_pkg::*;
#(
  parameter int         DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int         HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int         REPEAT_TICKS   = DEF_REPEAT_TICKS,
  parameter logic [7:0] FC_MIN         = DEF_FC_MIN,
  parameter logic [7:0] FC_MAX         = DEF_FC_MAX,
  parameter logic [1:0] MODE_MAX       = DEF_MODE_MAX
) (
  input  logic               clk_100kHz,
  input  logic               rst_,
  panel_controller_if.slave  pnl
);

  localparam int TMAX = (HOLD_TICKS > REPEAT_TICKS)
                      ? HOLD_TICKS : REPEAT_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  logic [1:0]    h_lvl, h_prs;
  logic [1:0]    v_lvl, v_prs;
  logic          h_up, h_dn;

  logic [1:0]    mode_q;
  logic          mode_evt_q;
  logic [7:0]    fc_q, fc_n;
  logic          fc_evt_q;

  logic [1:0]    st, st_n;
  logic [TW-1:0] tmr, tmr_n;
  logic          dir, dir_n;
  logic          step;

  for (genvar i = 0; i < 2; i++) begin : g_pb
    pb_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_h (
      .clk_100kHz (clk_100kHz),
      .rst_       (rst_),
      .raw        (pnl.h_pb[i]),
      .level      (h_lvl[i]),
      .press      (h_prs[i])
    );
    pb_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_v (
      .clk_100kHz (clk_100kHz),
      .rst_       (rst_),
      .raw        (pnl.v_pb[i]),
      .level      (v_lvl[i]),
      .press      (v_prs[i])
    );
  end

  assign h_up = h_prs[MODE_UP] & h_lvl[MODE_UP];
  assign h_dn = h_prs[MODE_DN] & h_lvl[MODE_DN];

  // Mode up has priority when both presses coincide.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      mode_q     <= RST_MODE;
      mode_evt_q <= 1'b0;
    end else begin
      mode_evt_q <= 1'b0;
      priority case (1'b1)
        h_up: begin
          if (mode_q < MODE_MAX) begin
            mode_q     <= mode_q + 2'd1;
            mode_evt_q <= 1'b1;
          end
        end
        h_dn: begin
          if (mode_q != 2'd0) begin
            mode_q     <= mode_q - 2'd1;
            mode_evt_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_n  = st;
    tmr_n = tmr;
    dir_n = dir;
    step  = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (&v_lvl) begin
          st_n = ST_LOCK;
        end else if (v_prs[FC_UP]) begin
          step  = 1'b1;
          dir_n = FC_UP;
          tmr_n = TW'(HOLD_TICKS - 1);
          st_n  = ST_HOLD;
        end else if (v_prs[FC_DN]) begin
          step  = 1'b1;
          dir_n = FC_DN;
          tmr_n = TW'(HOLD_TICKS - 1);
          st_n  = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (&v_lvl) begin
          st_n = ST_LOCK;
        end else if (!v_lvl[dir]) begin
          st_n = ST_IDLE;
        end else if (tmr == '0) begin
          step  = 1'b1;
          tmr_n = TW'(REPEAT_TICKS - 1);
          st_n  = ST_REPEAT;
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      ST_LOCK: begin
        if (v_lvl == 2'b00) st_n = ST_IDLE;
      end
      default: st_n = ST_IDLE;
    endcase
  end

  always_comb begin
    fc_n = fc_q;
    if (dir_n == FC_UP) begin
      fc_n = (fc_q == FC_MAX) ? FC_MIN : fc_q + 8'd1;
    end else begin
      fc_n = (fc_q == FC_MIN) ? FC_MAX : fc_q - 8'd1;
    end
  end

  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      st       <= ST_IDLE;
      tmr      <= '0;
      dir      <= FC_UP;
      fc_q     <= FC_MIN;
      fc_evt_q <= 1'b0;
    end else begin
      st       <= st_n;
      tmr      <= tmr_n;
      dir      <= dir_n;
      fc_evt_q <= step;
      if (step) fc_q <= fc_n;
    end
  end

  assign pnl.mode      = mode_q;
  assign pnl.mode_evt  = mode_evt_q;
  assign pnl.freq_ctrl = fc_q;
  assign pnl.fc_evt    = fc_evt_q;

endmodule

// File: tb/tb_panel_controller.sv
// Directed bench for panel_controller with short tick
// counts: debounce 4, hold 20, repeat 5.
module tb_panel_controller;

  logic clk = 1'b0;
  logic rst_;
  int   checks = 0;
  int   passes = 0;
  int   mode_evts = 0;
  int   fc_evts = 0;

  panel_controller_if bus ();

  panel_controller #(
    .DEBOUNCE_TICKS (4),
    .HOLD_TICKS     (20),
    .REPEAT_TICKS   (5)
  ) dut (
    .clk_100kHz (clk),
    .rst_       (rst_),
    .pnl        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.mode_evt === 1'b1) mode_evts++;
    if (bus.fc_evt === 1'b1) fc_evts++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int m0, f0;
    rst_ = 1'b0;
    bus.h_pb = 2'b00;
    bus.v_pb = 2'b00;
    cyc(3);
    checks++;
    if (bus.mode !== 2'd0 || bus.freq_ctrl !== 8'd1)
      $display("FAIL reset_vals: mode=%0d fc=%0d want 0/1",
               bus.mode, bus.freq_ctrl);
    else passes++;
    checks++;
    if (bus.mode_evt !== 1'b0 || bus.fc_evt !== 1'b0)
      $display("FAIL reset_evt: %b%b want 00",
               bus.mode_evt, bus.fc_evt);
    else passes++;
    rst_ = 1'b1;
    m0 = mode_evts;
    f0 = fc_evts;
    cyc(50);
    checks++;
    if (bus.mode !== 2'd0 || bus.freq_ctrl !== 8'd1)
      $display("FAIL idle_vals: mode=%0d fc=%0d want 0/1",
               bus.mode, bus.freq_ctrl);
    else passes++;
    checks++;
    if (mode_evts != m0 || fc_evts != f0)
      $display("FAIL idle_evts: mode %0d fc %0d want 0/0",
               mode_evts - m0, fc_evts - f0);
    else passes++;
  endtask

  task automatic test_mode_step();
    logic [1:0] exp_m [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [1:0] prev;
    int m0;
    m0 = mode_evts;
    for (int i = 0; i < 5; i++) begin
      prev = bus.mode;
      bus.h_pb[1] = 1'b1;
      cyc(6);
      checks++;
      if (bus.mode !== prev || bus.mode_evt !== 1'b0)
        $display("FAIL mode_early%0d: mode=%0d evt=%b want %0d/0",
                 i, bus.mode, bus.mode_evt, prev);
      else passes++;
      cyc(1);
      checks++;
      if (bus.mode !== exp_m[i]
          || bus.mode_evt !== (exp_m[i] != prev))
        $display("FAIL mode_step%0d: mode=%0d evt=%b want %0d/%b",
                 i, bus.mode, bus.mode_evt, exp_m[i],
                 exp_m[i] != prev);
      else passes++;
      cyc(93);
      bus.h_pb[1] = 1'b0;
      cyc(20);
    end
    checks++;
    if (mode_evts - m0 != 3)
      $display("FAIL mode_evt_count: got %0d want 3",
               mode_evts - m0);
    else passes++;
  endtask

  task automatic test_async_reset();
    int m0;
    #2 rst_ = 1'b0;
    #1;
    checks++;
    if (bus.mode !== 2'd0 || bus.freq_ctrl !== 8'd1)
      $display("FAIL async_rst: mode=%0d fc=%0d want 0/1",
               bus.mode, bus.freq_ctrl);
    else passes++;
    bus.h_pb[1] = 1'b1;
    cyc(2);
    rst_ = 1'b1;
    m0 = mode_evts;
    cyc(30);
    checks++;
    if (bus.mode !== 2'd0 || mode_evts != m0)
      $display("FAIL held_thru_rst: mode=%0d evts=%0d want 0/0",
               bus.mode, mode_evts - m0);
    else passes++;
    bus.h_pb[1] = 1'b0;
    cyc(20);
    bus.h_pb[1] = 1'b1;
    cyc(7);
    checks++;
    if (bus.mode !== 2'd1 || bus.mode_evt !== 1'b1)
      $display("FAIL repress_after_rst: mode=%0d evt=%b want 1/1",
               bus.mode, bus.mode_evt);
    else passes++;
    cyc(5);
    bus.h_pb[1] = 1'b0;
    cyc(20);
  endtask

  task automatic test_fc_debounce();
    logic bounce [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int f0;
    f0 = fc_evts;
    for (int i = 0; i < 5; i++) begin
      bus.v_pb[0] = bounce[i];
      cyc(1);
    end
    bus.v_pb[0] = 1'b1;
    cyc(6);
    checks++;
    if (bus.freq_ctrl !== 8'd1)
      $display("FAIL bounce_early: fc=%0d want 1", bus.freq_ctrl);
    else passes++;
    cyc(1);
    checks++;
    if (bus.freq_ctrl !== 8'd2 || bus.fc_evt !== 1'b1)
      $display("FAIL bounce_step: fc=%0d evt=%b want 2/1",
               bus.freq_ctrl, bus.fc_evt);
    else passes++;
    cyc(3);
    bus.v_pb[0] = 1'b0;
    cyc(20);
    checks++;
    if (fc_evts - f0 != 1 || bus.freq_ctrl !== 8'd2)
      $display("FAIL bounce_once: evts=%0d fc=%0d want 1/2",
               fc_evts - f0, bus.freq_ctrl);
    else passes++;
    f0 = fc_evts;
    bus.v_pb[0] = 1'b1;
    cyc(3);
    bus.v_pb[0] = 1'b0;
    cyc(20);
    checks++;
    if (fc_evts != f0 || bus.freq_ctrl !== 8'd2)
      $display("FAIL glitch3: evts=%0d fc=%0d want 0/2",
               fc_evts - f0, bus.freq_ctrl);
    else passes++;
  endtask

  task automatic test_fc_wrap();
    logic [1:0] btn [3] = '{2'b10, 2'b10, 2'b01};
    logic [7:0] exp_f [3] = '{8'd1, 8'd128, 8'd1};
    for (int i = 0; i < 3; i++) begin
      bus.v_pb = btn[i];
      cyc(7);
      checks++;
      if (bus.freq_ctrl !== exp_f[i] || bus.fc_evt !== 1'b1)
        $display("FAIL wrap%0d: fc=%0d evt=%b want %0d/1",
                 i, bus.freq_ctrl, bus.fc_evt, exp_f[i]);
      else passes++;
      cyc(3);
      bus.v_pb = 2'b00;
      cyc(20);
    end
  endtask

  task automatic test_repeat();
    logic [7:0] fexp;
    logic ev;
    int f0;
    fexp = 8'd1;
    f0 = fc_evts;
    bus.v_pb[0] = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      cyc(1);
      ev = (k == 7) || (k == 27) || (k == 32)
        || (k == 37) || (k == 42);
      if (ev) fexp = fexp + 8'd1;
      checks++;
      if (bus.fc_evt !== ev || bus.freq_ctrl !== fexp)
        $display("FAIL repeat_t%0d: fc=%0d evt=%b want %0d/%b",
                 k, bus.freq_ctrl, bus.fc_evt, fexp, ev);
      else passes++;
      // raw release lands so the level drops right after the +42 step
      if (k == 38) bus.v_pb[0] = 1'b0;
    end
    cyc(20);
    checks++;
    if (fc_evts - f0 != 5 || bus.freq_ctrl !== 8'd6)
      $display("FAIL repeat_total: evts=%0d fc=%0d want 5/6",
               fc_evts - f0, bus.freq_ctrl);
    else passes++;
  endtask

  task automatic test_lock();
    int f1;
    bus.v_pb[0] = 1'b1;
    cyc(35);
    checks++;
    if (bus.freq_ctrl !== 8'd9)
      $display("FAIL lock_pre: fc=%0d want 9", bus.freq_ctrl);
    else passes++;
    bus.v_pb[1] = 1'b1;
    cyc(40);
    checks++;
    if (bus.freq_ctrl !== 8'd10)
      $display("FAIL lock_both: fc=%0d want 10", bus.freq_ctrl);
    else passes++;
    f1 = fc_evts;
    bus.v_pb[0] = 1'b0;
    cyc(30);
    checks++;
    if (bus.freq_ctrl !== 8'd10 || fc_evts != f1)
      $display("FAIL lock_one: fc=%0d evts=%0d want 10/0",
               bus.freq_ctrl, fc_evts - f1);
    else passes++;
    bus.v_pb[1] = 1'b0;
    cyc(20);
    bus.v_pb[1] = 1'b1;
    cyc(7);
    checks++;
    if (bus.freq_ctrl !== 8'd9 || bus.fc_evt !== 1'b1)
      $display("FAIL unlock_dn: fc=%0d evt=%b want 9/1",
               bus.freq_ctrl, bus.fc_evt);
    else passes++;
    cyc(3);
    bus.v_pb[1] = 1'b0;
    cyc(20);
    checks++;
    if (fc_evts - f1 != 1 || bus.freq_ctrl !== 8'd9)
      $display("FAIL unlock_once: evts=%0d fc=%0d want 1/9",
               fc_evts - f1, bus.freq_ctrl);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_mode_step();
    test_async_reset();
    test_fc_debounce();
    test_fc_wrap();
    test_repeat();
    test_lock();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
